credit_return_tracker: RTL and testbench

- Per-channel credit counter array; the consuming end of the inc/dec credit protocol.
- A sender spends one credit per transfer (post-decrement). The downstream side returns credits (pre-increment).
- Sits between an upstream arbiter and a downstream buffer. Gates sends per channel and flags protocol errors.
- A sequential init walker loads credits one channel per cycle after reset.

---
 rtl/credit_return_tracker_pkg.sv | 19 +
 rtl/credit_return_tracker_if.sv | 31 +++
 rtl/credit_return_tracker_slot.sv | 44 ++++
 rtl/credit_return_tracker.sv | 153 +++++++++++++++
 tb/tb_credit_return_tracker.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/credit_return_tracker_pkg.sv
// Shared types and default sizing for the credit return tracker.
// Holds the tracker FSM state enum, default parameter values and the
// channel-index width helper used by the interface and the top level.
package credit_tracker_pkg;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_INIT_CREDIT = 8;
  localparam int unsigned DEF_MAX_CREDIT  = 15;
  localparam int unsigned STATS_W         = 16;

  typedef enum logic {INIT, RUN} trk_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/credit_return_tracker_if.sv
// Send/return handshake bundle between the upstream arbiter, the downstream
// buffer and the credit tracker.
//   send_valid/send_ch : sender spends one credit on send_ch
//   send_ready         : tracker allows the send (combinational)
//   ret_valid/ret_ch   : one credit returned on ret_ch
// master = sender/returner side, slave = tracker side.
interface credit_return_tracker_if
  import credit_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
) ();

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic            send_valid;
  logic [CH_W-1:0] send_ch;
  logic            send_ready;
  logic            ret_valid;
  logic [CH_W-1:0] ret_ch;

  modport master (
    output send_valid, send_ch, ret_valid, ret_ch,
    input  send_ready
  );

  modport slave (
    input  send_valid, send_ch, ret_valid, ret_ch,
    output send_ready
  );

endinterface

// File: rtl/credit_return_tracker_slot.sv
// One channel's credit counter with saturating net update.
// Ports: clk, rst (sync, active-high); load/load_val (init walker write,
// highest priority); dec (fired send); inc (credit return);
// cnt (counter register), at_max (cnt at ceiling), nonzero (cnt != 0).
module credit_slot #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAX_CREDIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max  = (cnt_q >= CNT_W'(MAX_CREDIT));
  assign nonzero = |cnt_q;
  assign cnt     = cnt_q;

  // Simultaneous inc and dec cancel; each direction saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && !dec) begin
      if (!at_max) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (nonzero) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/credit_return_tracker.sv
// Per-channel credit tracker: consuming end of the inc/dec credit protocol.
// After reset an init walker loads INIT_CREDIT into one channel per cycle;
// then sends spend credits and returns replenish them, with sticky
// overflow/underflow error flags.
// Ports: clk, rst (sync, active-high); bus (slave handshake bundle);
// credit_avail (per-channel nonzero), credit_cnt (flat counters, channel i
// at [i*CNT_W +: CNT_W]), init_done, err_overflow, err_underflow.
// Build option CREDIT_TRACKER_STATS_EN adds fire_count (wrapping count of
// fired sends) and peak_ch_credit (max counter value seen since init end).
module credit_return_tracker
  import credit_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned INIT_CREDIT = DEF_INIT_CREDIT,
  parameter int unsigned MAX_CREDIT  = DEF_MAX_CREDIT
) (
  input  logic                    clk,
  input  logic                    rst,
  credit_return_tracker_if.slave  bus,
  output logic [NUM_CH-1:0]       credit_avail,
  output logic [NUM_CH*CNT_W-1:0] credit_cnt,
  output logic                    init_done,
  output logic                    err_overflow,
  output logic                    err_underflow
`ifdef CREDIT_TRACKER_STATS_EN
  ,
  output logic [STATS_W-1:0]      fire_count,
  output logic [CNT_W-1:0]        peak_ch_credit
`endif
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  trk_state_e      state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic            init_done_q, init_done_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;

  logic [CH_W-1:0] send_ch;
  logic [CH_W-1:0] ret_ch;
  logic            fire;
  logic            ret_fire;
  logic            same_ch;

  logic [NUM_CH-1:0] at_max;
  logic [NUM_CH-1:0] nonzero;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  assign send_ch        = bus.send_ch;
  assign ret_ch         = bus.ret_ch;
  assign bus.send_ready = init_done_q && nonzero[send_ch];
  assign fire           = bus.send_valid && bus.send_ready;
  assign ret_fire       = init_done_q && bus.ret_valid;
  assign same_ch        = (send_ch == ret_ch);

  // Channel decode into one counter slot per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    credit_slot #(
      .CNT_W      (CNT_W),
      .MAX_CREDIT (MAX_CREDIT)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     ((state_q == INIT) && (idx_q == CH_W'(i))),
      .load_val (CNT_W'(INIT_CREDIT)),
      .dec      (fire && (send_ch == CH_W'(i))),
      .inc      (ret_fire && (ret_ch == CH_W'(i))),
      .cnt      (cnt[i]),
      .at_max   (at_max[i]),
      .nonzero  (nonzero[i])
    );
    assign credit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign credit_avail  = nonzero;
  assign init_done     = init_done_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

  // Init walker and error detection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + CH_W'(1);
        if (idx_q == CH_W'(NUM_CH - 1)) begin
          idx_d       = '0;
          init_done_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (bus.send_valid && !bus.send_ready) err_unf_d = 1'b1;
        // A fire on the same channel absorbs the return, so no overflow.
        if (ret_fire && at_max[ret_ch] && !(fire && same_ch)) err_ovf_d = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

`ifdef CREDIT_TRACKER_STATS_EN
  logic [STATS_W-1:0] fire_count_q, fire_count_d;
  logic [CNT_W-1:0]   peak_q, peak_d;

  // Peak samples the live counters every RUN cycle, so it trails them by one.
  always_comb begin
    fire_count_d = fire_count_q;
    peak_d       = peak_q;
    if (fire) fire_count_d = fire_count_q + STATS_W'(1);
    if (state_q == RUN) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (cnt[i] > peak_d) peak_d = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_count_q <= '0;
      peak_q       <= '0;
    end else begin
      fire_count_q <= fire_count_d;
      peak_q       <= peak_d;
    end
  end

  assign fire_count     = fire_count_q;
  assign peak_ch_credit = peak_q;
`endif

endmodule

// File: tb/tb_credit_return_tracker.sv
// Randomized plus directed bench for credit_return_tracker, checked every
// cycle against a behavioural per-channel credit model.
module tb_credit_return_tracker;
  import credit_tracker_pkg::*;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned INIT_CREDIT = 8;
  localparam int unsigned MAX_CREDIT  = 15;
  localparam int unsigned CH_W        = ch_idx_w(NUM_CH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  credit_return_tracker_if #(.NUM_CH(NUM_CH)) bus ();

  logic [NUM_CH-1:0]       credit_avail;
  logic [NUM_CH*CNT_W-1:0] credit_cnt;
  logic                    init_done;
  logic                    err_overflow;
  logic                    err_underflow;
`ifdef CREDIT_TRACKER_STATS_EN
  logic [15:0]             fire_count;
  logic [CNT_W-1:0]        peak_ch_credit;
`endif

  credit_return_tracker #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .INIT_CREDIT (INIT_CREDIT),
    .MAX_CREDIT  (MAX_CREDIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .credit_avail  (credit_avail),
    .credit_cnt    (credit_cnt),
    .init_done     (init_done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef CREDIT_TRACKER_STATS_EN
    ,
    .fire_count     (fire_count),
    .peak_ch_credit (peak_ch_credit)
`endif
  );

  // Reference model state
  int m_cred [NUM_CH];
  int m_loaded;
  bit m_done, m_ovf, m_unf;
  int m_fires, m_peak;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input int ch);
    return m_done && (m_cred[ch] != 0);
  endfunction

  task automatic model_step(input bit r, input bit sv, input int sc, input bit rv, input int rc);
    bit fire;
    if (r) begin
      foreach (m_cred[i]) m_cred[i] = 0;
      m_loaded = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_fires = 0; m_peak = 0;
      return;
    end
    if (!m_done) begin
      m_cred[m_loaded] = INIT_CREDIT;
      m_loaded++;
      if (m_loaded == NUM_CH) m_done = 1;
      return;
    end
    foreach (m_cred[i]) if (m_cred[i] > m_peak) m_peak = m_cred[i];
    fire = sv && (m_cred[sc] != 0);
    if (sv && !fire) m_unf = 1;
    if (fire) m_fires = (m_fires + 1) % 65536;
    if (!(fire && rv && sc == rc)) begin
      if (fire) m_cred[sc]--;
      if (rv) begin
        if (m_cred[rc] >= MAX_CREDIT) m_ovf = 1;
        else m_cred[rc]++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    logic [NUM_CH-1:0]       exp_avail;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cred[i]);
      exp_avail[i] = (m_cred[i] != 0);
    end
    check_eq("credit_cnt", credit_cnt, exp_cnt);
    check_eq("credit_avail", credit_avail, exp_avail);
    check_eq("init_done", init_done, m_done);
    check_eq("err_overflow", err_overflow, m_ovf);
    check_eq("err_underflow", err_underflow, m_unf);
`ifdef CREDIT_TRACKER_STATS_EN
    check_eq("fire_count", fire_count, 16'(m_fires));
    check_eq("peak_ch_credit", peak_ch_credit, CNT_W'(m_peak));
`endif
  endtask

  // One clock: drive at negedge, check send_ready, update model on the edge.
  task automatic cycle(input bit r, input bit sv, input int sc, input bit rv, input int rc);
    @(negedge clk);
    rst            = r;
    bus.send_valid = sv;
    bus.send_ch    = CH_W'(sc);
    bus.ret_valid  = rv;
    bus.ret_ch     = CH_W'(rc);
    #1;
    check_eq("send_ready", bus.send_ready, model_ready(sc));
    @(posedge clk);
    model_step(r, sv, sc, rv, rc);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [CNT_W-1:0] ch_val;
    bus.send_valid = 1'b0;
    bus.send_ch    = '0;
    bus.ret_valid  = 1'b0;
    bus.ret_ch     = '0;
    model_step(1'b1, 1'b0, 0, 1'b0, 0);

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Traffic during init must be ignored.
    for (int k = 0; k < NUM_CH; k++) cycle(0, 1, k, 1, k);
    check_eq("init_cnt_all", credit_cnt, 32'h0808_0808);
    check_eq("init_avail_all", credit_avail, 4'b1111);

    // Drain ch2 then one extra send -> underflow.
    for (int k = 0; k < 9; k++) cycle(0, 1, 2, 0, 0);
    ch_val = credit_cnt[2*CNT_W +: CNT_W];
    check_eq("ch2_drained", ch_val, 0);
    check_eq("underflow_set", err_underflow, 1'b1);

    // Fill ch0 to the ceiling, overflow, then same-cycle fire+return at max.
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    ch_val = credit_cnt[0 +: CNT_W];
    check_eq("ch0_at_max", ch_val, CNT_W'(MAX_CREDIT));

    cycle(0, 1, 1, 1, 3);
    cycle(0, 1, 1, 1, 1);
    ch_val = credit_cnt[1*CNT_W +: CNT_W];
    check_eq("ch1_after_pair", ch_val, 7);

    // Mid-run reset and re-init.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < NUM_CH; k++) cycle(0, 0, 0, 0, 0);

    // Five sends and four returns lifting ch0 to 12.
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    ch_val = credit_cnt[0 +: CNT_W];
    check_eq("ch0_lifted", ch_val, 12);
`ifdef CREDIT_TRACKER_STATS_EN
    check_eq("stats_fire5", fire_count, 16'd5);
    check_eq("stats_peak12", peak_ch_credit, CNT_W'(12));
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, NUM_CH - 1)),
            ($urandom_range(0, 2) != 0), int'($urandom_range(0, NUM_CH - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
